// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared state type and defaults for the mux select sequencer
package mux_seq_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = 3;
  localparam int DIR_LSB = 0;
  localparam int DIR_MSB = 1;
endpackage

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: holds a word on an external mux and steps its select to serialise the word
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int MSB_FIRST = DIR_LSB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] i_out,
  output logic [SEL_W-1:0] s_out,
  input  logic             o_in,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             done
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] FIRST_SEL = (MSB_FIRST != 0) ? LAST : '0;
  state_t state;
  logic [SEL_W-1:0] count;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i_out <= '0;
      s_out <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load_valid) begin
          i_out <= load_data;
          count <= '0;
          s_out <= FIRST_SEL;
          state <= SCAN;
        end
      end else if (ser_ready) begin
        if (count == LAST) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          count <= count + 1'b1;
          s_out <= (MSB_FIRST != 0) ? s_out - 1'b1 : s_out + 1'b1;
        end
      end
    end
  end
  assign load_ready = (state == IDLE);
  assign ser_valid  = (state == SCAN);
  assign ser_bit    = o_in;
  assign ser_last   = (state == SCAN) && (count == LAST);
endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Upstream controller for the 8:1 select mux (mux_8x1). It accepts an 8-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the mux select through every lane one position per accepted beat. The mux output is returned on o_in and forwarded as a serial bit stream with valid/ready and last flags. Together, this block and the mux form a parallel-to-serial converter.

Parameters:
WIDTH, 8, number of mux data lanes (bits per frame); must satisfy 2 <= WIDTH <= 2**SEL_W.
SEL_W, 3, width of the mux select bus.
MSB_FIRST, 0, 0 = select steps 0 up to WIDTH-1; 1 = select steps WIDTH-1 down to 0.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
load_valid  input  1  a word is offered on load_data.
load_ready  output  1  block can accept a word.
load_data  input  WIDTH  word to serialise.
i_out  output  WIDTH  registered data driven to mux input i.
s_out  output  SEL_W  registered select driven to mux input s.
o_in  input  1  mux output o (combinational function of i_out and s_out).
ser_valid  output  1  ser_bit holds a valid bit.
ser_ready  input  1  downstream accepts ser_bit.
ser_bit  output  1  serial data; equals o_in.
ser_last  output  1  the current beat is the final bit of the frame.
done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, i_out=0, s_out=0, count=0, done=0.
  - Derived outputs at reset: load_ready=1, ser_valid=0, ser_last=0.
  - Reset takes priority over every other event, including mid-frame; the partial frame is discarded and no done pulse is produced.
- FSM states: IDLE, SCAN.
  - load_ready = (state==IDLE).
  - ser_valid = (state==SCAN).
  - ser_bit = o_in, combinational passthrough with no added latency.
  - ser_last = (state==SCAN) && (count==WIDTH-1).
- IDLE: on load_valid && load_ready:
  - i_out <= load_data.
  - count <= 0.
  - s_out <= (MSB_FIRST ? WIDTH-1 : 0).
  - Next state is SCAN.
  - The first bit is valid in the cycle after the load.
- SCAN, beat accepted (ser_valid && ser_ready):
  - If count != WIDTH-1: count <= count+1; s_out <= s_out+1, or s_out-1 when MSB_FIRST. Stay in SCAN.
  - If count == WIDTH-1: go to IDLE and set done <= 1 for exactly one cycle. i_out and s_out hold their last values.
- SCAN, beat not accepted (ser_ready=0): s_out, i_out and count hold. ser_valid stays high, and ser_bit stays stable as long as the mux is stable.
- Throughput: with ser_ready held high, one bit per cycle. A frame occupies WIDTH SCAN cycles plus one IDLE cycle before the next load can be accepted, i.e. 1 bubble per frame.
- load_valid while in SCAN is ignored (load_ready=0); load_data is not sampled.
- count is a separate SEL_W-bit counter, so MSB_FIRST only changes the direction of s_out. s_out never leaves the range 0..WIDTH-1 and never wraps.
- done does not depend on ser_ready after the final accept. In the done cycle the block is already IDLE, so load_ready=1 and a new load can be accepted in that same cycle.
- No combinational path from load_valid to load_ready, or from ser_ready to ser_valid.

Decomposition:
- Shared package mux_seq_pkg: state typedef (IDLE, SCAN), default WIDTH/SEL_W constants, and the direction constants for MSB_FIRST.
- The beat counter and select stepping stay inline; no sub-module is required.
- Integration wrapper (not part of this block): mux_sel_sequencer and mux_8x1, connected by i_out→i, s_out→s, o→o_in.

Test Plan:
- Reset, then load 8'hB2 with MSB_FIRST=0 and ser_ready=1 → ser_bit = 0,1,0,0,1,1,0,1 on 8 consecutive cycles with s_out = 0..7; ser_last only on the s_out=7 beat; done pulses in the next cycle; load_ready returns to 1.
- Same word with MSB_FIRST=1 → s_out = 7..0, ser_bit = 1,0,1,1,0,0,1,0; ser_last when s_out=0.
- Load 8'h5A and toggle ser_ready 1,0,0,1,... → s_out and ser_bit hold during stalls; exactly 8 accepted beats = 0,1,0,1,1,0,1,0; a single done pulse.
- Assert load_valid with 8'hFF during SCAN of 8'h00 → ignored; all 8 bits are 0; i_out stays 00 until a later IDLE load.
- Assert rst after 3 accepted beats → next cycle: IDLE, s_out=0, i_out=0, ser_valid=0, no done; a fresh load of 8'h01 then emits 1 followed by seven 0s.
- Back-to-back loads 8'hF0 then 8'h0F with load_valid held high → the second load is accepted in the done cycle; outputs are 0,0,0,0,1,1,1,1 then 1,1,1,1,0,0,0,0, with exactly one idle cycle between frames.
